rf_writeback_arbiter: RTL
=========================

Name: rf_writeback_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: ALU/execute and memory/load.
- Each source has its own small FIFO. A round-robin arbiter drains the FIFOs onto a registered write port (write_enabled/write_addr/write_data).
- Exports a 32-bit pending-write mask so the issue stage can stall on RAW hazards against queued writebacks.
- Sits between the EX/MEM writeback pipeline registers and the register file.

Parameters:
- DEPTH, 2, entries per source FIFO (power of 2, >=2)
- DATA_W, 64, writeback data width
- ADDR_W, 5, register address width (32 registers; address 31 is the zero register)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU FIFO can accept
- alu_addr  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- mem_valid  input  1  load writeback request
- mem_ready  output  1  MEM FIFO can accept
- mem_addr  input  ADDR_W  load destination register
- mem_data  input  DATA_W  load data
- write_enabled  output  1  register-file write strobe
- write_addr  output  ADDR_W  register-file write address
- write_data  output  DATA_W  register-file write data
- pending_mask  output  32  bit r=1 while a write to register r is queued or on the write port
- (WB_FWD_EN only) fwd_addr  input  ADDR_W; fwd_hit  output  1; fwd_data  output  DATA_W

Behaviour:
- Reset (reset_n=0, async): both FIFOs empty; write_enabled=0; write_addr=0; write_data=0; pending_mask=0; RR pointer set so ALU wins the first tie; alu_ready=mem_ready=1 once reset deasserts.
- Accept: a transfer occurs at a rising edge when valid&&ready. ready = FIFO count < DEPTH and depends only on count, never on valid. A full FIFO stays not-ready even when it pops in the same cycle (no pass-through).
- Zero register: an accepted request with addr==31 is consumed (the handshake completes) but is never stored, written or added to pending_mask.
- Arbitration, per cycle:
  - If exactly one FIFO is non-empty, pop its head.
  - If both are non-empty, grant the source that did not win the last contested grant. The RR pointer updates only on contested grants.
  - Popped entry is registered onto write_addr/write_data with write_enabled=1 for exactly one cycle.
  - If both FIFOs are empty, write_enabled=0 and write_addr/write_data hold their last values.
- Throughput: one register-file write per cycle maximum. A single source with no contention sustains 1 write/cycle.
- Latency: request accepted at edge N -> write_enabled high in the cycle after edge N+1 -> register file captures at edge N+2. An empty FIFO cannot be popped in the same cycle it is written.
- Ordering: each source is strict FIFO. No ordering is guaranteed between sources. Upstream must not have two in-flight writes to the same register; the issue stage enforces this using pending_mask. Behaviour on violation is undefined.
- pending_mask: bit set at the accept edge. Bit cleared at the edge that ends the cycle in which that entry's write_enabled is high. If an accept to register r and the retire of r coincide on one edge, the bit remains set. Bit 31 is always 0.
- Reset mid-operation: queued and in-flight writes are discarded; no write_enabled pulse follows.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- Defined:
  - Adds the fwd_* ports.
  - fwd_hit=1 combinationally when fwd_addr!=31 and fwd_addr matches a valid FIFO entry or the active output stage (write_enabled=1).
  - fwd_data returns that entry's data. Priority is output stage > FIFO head > younger entries; there is a single match by the ordering rule.
- Undefined: the fwd_* ports are absent and no compare logic is built; issue must stall on pending_mask.

Test Plan:
- Reset, then single ALU write addr=5 data=0xDEAD_BEEF at edge N -> write_enabled=1, addr=5, data=0xDEADBEEF during cycle N+1..N+2; pending_mask[5]=1 from N to N+2, then 0.
- Both sources valid every cycle with addrs 1,2,3 (ALU) and 10,11,12 (MEM) -> writes interleave 1,10,2,11,3,12; exactly one write_enabled per cycle; ready deasserts when a FIFO holds DEPTH entries.
- MEM-only burst of 4 with DEPTH=2 while ALU is idle -> mem_ready toggles as expected; 4 consecutive writes in order; no gaps after the first.
- Request to addr=31 data=0xFFFF -> handshake completes; no write_enabled; pending_mask stays 0.
- reset_n pulled low with 2 entries queued in each FIFO -> all outputs 0 immediately (async); no writes after release; ready=1.
- RF_WB_FWD_EN: queue ALU addr=7 data=0x1234 while MEM writes are in flight; fwd_addr=7 -> fwd_hit=1, fwd_data=0x1234 until the retire edge; fwd_addr=31 -> fwd_hit=0.

Source files
------------

// File: rtl/rf_writeback_arbiter.sv
// Purpose: shares the register-file write port between ALU and load writebacks via two FIFOs and a round-robin drain.
// Latency: accept at edge N -> write_enabled high for one cycle after edge N+1 -> register file captures at edge N+2.
// Backpressure: *_ready = FIFO count < DEPTH (independent of valid); a full FIFO stays not-ready even while popping.
//
// Ports: clk/reset_n (async active-low); alu_* and mem_* valid/ready request channels (addr, data);
//        write_enabled/write_addr/write_data registered write port; pending_mask = registers with queued writes.
// Optional build macro RF_WB_FWD_EN adds fwd_addr/fwd_hit/fwd_data, a lookup of queued and in-flight write data.
module rf_writeback_arbiter #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              write_enabled,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] write_data,
   output logic [31:0]       pending_mask
`ifdef RF_WB_FWD_EN
   ,
   input  logic [ADDR_W-1:0] fwd_addr,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

   // Source index 0 = ALU, 1 = MEM.
   logic [ADDR_W-1:0] r_q_addr [2][DEPTH];
   logic [DATA_W-1:0] r_q_data [2][DEPTH];
   logic [PW-1:0]     r_wr [2];
   logic [PW-1:0]     r_rd [2];
   logic [PW:0]       r_cnt [2];
   logic              r_rr;      // 0: ALU wins the next contested grant
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic [31:0]       r_mask;

   logic [ADDR_W-1:0] w_in_addr [2];
   logic [DATA_W-1:0] w_in_data [2];
   logic [1:0]        w_in_vld;
   logic [1:0]        w_rdy;
   logic [1:0]        w_push;
   logic [1:0]        w_ne;
   logic [1:0]        w_pop;
   logic              w_contest;
   logic              w_gnt;
   logic [31:0]       w_set;
   logic [31:0]       w_clr;
   logic [31:0]       w_mask_nxt;

   always_comb begin
      w_in_vld     = {mem_valid, alu_valid};
      w_in_addr[0] = alu_addr;
      w_in_addr[1] = mem_addr;
      w_in_data[0] = alu_data;
      w_in_data[1] = mem_data;
      w_set        = '0;
      for (int s = 0; s < 2; s++) begin
         w_rdy[s] = (r_cnt[s] < (PW+1)'(DEPTH));
         w_ne[s]  = (r_cnt[s] != '0);
         // Zero-register writes complete the handshake but are dropped here.
         w_push[s] = w_in_vld[s] && w_rdy[s] && (w_in_addr[s] != ZERO_REG);
         if (w_push[s]) begin
            w_set[w_in_addr[s]] = 1'b1;
         end
      end
      w_contest = w_ne[0] && w_ne[1];
      w_pop[0]  = w_ne[0] && (!w_ne[1] || !r_rr);
      w_pop[1]  = w_ne[1] && (!w_ne[0] ||  r_rr);
      w_gnt     = w_pop[1];
      w_clr     = '0;
      if (r_we) begin
         w_clr[r_waddr] = 1'b1;
      end
      // Set after clear: an accept coinciding with the retire of the same register keeps the bit.
      w_mask_nxt     = (r_mask & ~w_clr) | w_set;
      w_mask_nxt[31] = 1'b0;
   end

   // Entry storage needs no reset; validity is tracked by the counters.
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (w_push[s]) begin
            r_q_addr[s][r_wr[s]] <= w_in_addr[s];
            r_q_data[s][r_wr[s]] <= w_in_data[s];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < 2; s++) begin
            r_wr[s]  <= '0;
            r_rd[s]  <= '0;
            r_cnt[s] <= '0;
         end
         r_rr    <= 1'b0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_mask  <= '0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (w_push[s]) begin
               r_wr[s] <= r_wr[s] + 1'b1;
            end
            if (w_pop[s]) begin
               r_rd[s] <= r_rd[s] + 1'b1;
            end
            case ({w_push[s], w_pop[s]})
               2'b10:   r_cnt[s] <= r_cnt[s] + 1'b1;
               2'b01:   r_cnt[s] <= r_cnt[s] - 1'b1;
               default: r_cnt[s] <= r_cnt[s];
            endcase
         end
         // Pointer moves only on contested grants, handing the next tie to the loser.
         if (w_contest) begin
            r_rr <= ~r_rr;
         end
         r_we <= |w_pop;
         if (|w_pop) begin
            r_waddr <= r_q_addr[w_gnt][r_rd[w_gnt]];
            r_wdata <= r_q_data[w_gnt][r_rd[w_gnt]];
         end
         r_mask <= w_mask_nxt;
      end
   end

   assign alu_ready     = w_rdy[0];
   assign mem_ready     = w_rdy[1];
   assign write_enabled = r_we;
   assign write_addr    = r_waddr;
   assign write_data    = r_wdata;
   assign pending_mask  = r_mask;

`ifdef RF_WB_FWD_EN
   logic [PW-1:0] w_fwd_idx;

   // Scan youngest to oldest so older entries override; the output stage overrides everything.
   always_comb begin
      fwd_hit   = 1'b0;
      fwd_data  = '0;
      w_fwd_idx = '0;
      if (fwd_addr != ZERO_REG) begin
         for (int s = 0; s < 2; s++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
               w_fwd_idx = r_rd[s] + PW'(k);
               if (((PW+1)'(k) < r_cnt[s]) && (r_q_addr[s][w_fwd_idx] == fwd_addr)) begin
                  fwd_hit  = 1'b1;
                  fwd_data = r_q_data[s][w_fwd_idx];
               end
            end
         end
         if (r_we && (r_waddr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = r_wdata;
         end
      end
   end
`endif

endmodule
